countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Four-digit BCD MM:SS down-counter: the count-down counterpart of the stopwatch's up-counting time path.
- Loads a preset and decrements once per enabled tick while running.
- Signals expiry with a one-cycle done pulse and an expired level.
- Sits beside the stopwatch counter.
- Fed by the shared tick generator; drives the same 7-segment display path.

Parameters:
- PRESCALE, 1, number of tick pulses per one-second decrement; legal range 1..255.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle enable pulse from the tick generator.
- load  input  1  one-cycle pulse; latch preset into counter.
- start_stop  input  1  one-cycle pulse; toggle run/pause.
- preset_min  input  8  BCD minutes {tens[7:4], ones[3:0]}.
- preset_sec  input  8  BCD seconds {tens[7:4], ones[3:0]}.
- time_reading  output  16  {min_tens, min_ones, sec_tens, sec_ones}, BCD, registered.
- running  output  1  high while in RUN.
- expired  output  1  high while in EXPIRED.
- done  output  1  one-cycle pulse on reaching 00:00.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- States: IDLE, RUN, PAUSE, EXPIRED.
- Reset values: state IDLE; time_reading 16'h0000; prescaler 0; running 0; expired 0; done 0.
- Priority per edge: reset > load > start_stop > tick.
- load, any state:
  - Counter takes the clamped preset.
  - Clamp rules: any digit >9 becomes 9; sec_tens >5 becomes 5.
  - Preset register is updated; prescaler cleared; state IDLE; expired cleared; done 0.
  - start_stop and tick in the same cycle are ignored.
- start_stop:
  - IDLE with count != 0 -> RUN.
  - IDLE with count == 0 -> stays IDLE.
  - RUN -> PAUSE.
  - PAUSE -> RUN.
  - EXPIRED -> ignored.
  - A tick in the same cycle as start_stop is ignored; prescaler unchanged.
- tick in RUN:
  - Prescaler increments.
  - When prescaler == PRESCALE-1: prescaler wraps to 0 and the count decrements by one second.
  - PRESCALE=1: every tick decrements.
- tick in IDLE, PAUSE or EXPIRED: ignored; prescaler holds.
- Decrement arithmetic, BCD borrow chain:
  - sec_ones 0->9 borrows sec_tens; sec_tens 0->5 borrows min_ones.
  - min_ones 0->9 borrows min_tens; otherwise digit-1.
  - 00:00 is never decremented.
- Expiry:
  - On the edge where the count becomes 00:00, state -> EXPIRED.
  - done is high exactly the following cycle; expired is high from that cycle until load or reset.
- Latency: time_reading, running, expired and done are registered and change one cycle after the sampling edge.
- Reset mid-run overrides everything; the preset register is also cleared to 00:00.
- Max count 99:59.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - On reaching 00:00, done pulses as normal.
  - The counter reloads the stored preset on the same edge and stays in RUN; EXPIRED is never entered; expired stays 0.
  - If the stored preset is 00:00, it behaves as if undefined.
- Undefined: behaviour as above; EXPIRED holds until load or reset.

Test Plan:
- reset; load preset_min=8'h01, preset_sec=8'h00; start_stop; 1 tick (PRESCALE=1) -> time_reading 16'h0059, running=1.
- load 00:02; start; 2 ticks -> 16'h0001, then 16'h0000; done high exactly 1 cycle; expired=1; running=0; further ticks and start_stop leave state unchanged.
- load preset_sec=8'h7C, preset_min=8'hA3 -> time_reading 16'h9359 (clamped).
- Running at 00:10; start_stop and tick in the same cycle -> PAUSE, reading stays 16'h0010; 3 ticks -> unchanged; start_stop then tick -> 16'h0009.
- PRESCALE=4; load 00:05; start; 7 ticks -> 16'h0004; load during RUN at 00:04 with preset 00:30 -> 16'h0030, state IDLE, prescaler 0.
- COUNTDOWN_AUTO_RELOAD_EN defined; load 00:01; start; tick -> done pulse, reading 16'h0001, running=1, expired=0.

Source files
------------

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Four-digit BCD MM:SS down-counter. A preset is loaded with
//                'load', start_stop toggles run/pause, and every PRESCALE
//                ticks while running the count drops by one second. Reaching
//                00:00 gives a one-cycle 'done' pulse and holds the 'expired'
//                level until the next load or reset.
//
//  Parameters  : PRESCALE      - tick pulses per one-second decrement (1..255)
//
//  Ports       : clk           - system clock, rising edge
//                reset         - synchronous active-high reset
//                tick          - one-cycle enable from the tick generator
//                load          - one-cycle pulse, latch clamped preset
//                start_stop    - one-cycle pulse, toggle run/pause
//                preset_min    - BCD minutes {tens, ones}
//                preset_sec    - BCD seconds {tens, ones}
//                time_reading  - {min_tens, min_ones, sec_tens, sec_ones}
//                running       - high while running
//                expired       - high while expired
//                done          - one-cycle pulse on reaching 00:00
//
//  Options     : COUNTDOWN_AUTO_RELOAD_EN - when defined, reaching 00:00
//                reloads the stored preset and keeps running (a stored
//                preset of 00:00 falls back to normal expiry).
//
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        load,
    input  logic        start_stop,
    input  logic [7:0]  preset_min,
    input  logic [7:0]  preset_sec,
    output logic [15:0] time_reading,
    output logic        running,
    output logic        expired,
    output logic        done
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSE   = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    localparam logic [7:0] c_presc_last = 8'(PRESCALE - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_count;
    logic [15:0] w_count_nxt;
    logic [7:0]  r_presc;
    logic [7:0]  w_presc_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic [15:0] w_clamped;
    logic [15:0] w_count_dec;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [15:0] r_preset;
    logic [15:0] w_preset_nxt;
`endif

    function automatic logic [3:0] f_clamp(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // One-second BCD decrement with borrow ripple. Caller guarantees the
    // input is non-zero, so min_tens never underflows.
    function automatic logic [15:0] f_bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    assign w_clamped = {f_clamp(preset_min[7:4], 4'd9), f_clamp(preset_min[3:0], 4'd9),
                        f_clamp(preset_sec[7:4], 4'd5), f_clamp(preset_sec[3:0], 4'd9)};
    assign w_count_dec = f_bcd_dec(r_count);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_presc_nxt = r_presc;
        w_done_nxt  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        w_preset_nxt = r_preset;
`endif
        if (load) begin
            w_count_nxt = w_clamped;
            w_presc_nxt = 8'd0;
            w_state_nxt = S_IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            w_preset_nxt = w_clamped;
`endif
        end else if (start_stop) begin
            // A coincident tick is dropped; prescaler keeps its phase.
            case (r_state)
                S_IDLE:  if (r_count != 16'h0000) w_state_nxt = S_RUN;
                S_RUN:   w_state_nxt = S_PAUSE;
                S_PAUSE: w_state_nxt = S_RUN;
                default: w_state_nxt = r_state;
            endcase
        end else if (tick && (r_state == S_RUN)) begin
            if (r_presc == c_presc_last) begin
                w_presc_nxt = 8'd0;
                if (r_count != 16'h0000) begin
                    w_count_nxt = w_count_dec;
                    if (w_count_dec == 16'h0000) begin
                        w_done_nxt = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        if (r_preset != 16'h0000) begin
                            w_count_nxt = r_preset;
                        end else begin
                            w_state_nxt = S_EXPIRED;
                        end
`else
                        w_state_nxt = S_EXPIRED;
`endif
                    end
                end
            end else begin
                w_presc_nxt = r_presc + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= 16'h0000;
            r_presc <= 8'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_presc <= w_presc_nxt;
            r_done  <= w_done_nxt;
        end
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_preset <= 16'h0000;
        end else begin
            r_preset <= w_preset_nxt;
        end
    end
`endif

    assign time_reading = r_count;
    assign running      = (r_state == S_RUN);
    assign expired      = (r_state == S_EXPIRED);
    assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Directed-vector bench for countdown_timer. One instance
//                with PRESCALE=1 runs a table of single-cycle vectors; a
//                second instance with PRESCALE=4 runs a hand sequence for
//                prescaler phase. Honors COUNTDOWN_AUTO_RELOAD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

    typedef struct {
        logic        ld;
        logic        ss;
        logic        tk;
        logic [7:0]  pm;
        logic [7:0]  ps;
        logic [15:0] t;
        logic        run;
        logic        exp;
        logic        dn;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0, load = 1'b0, start_stop = 1'b0;
    logic [7:0]  preset_min = 8'h00, preset_sec = 8'h00;
    logic [15:0] time_reading;
    logic        running, expired, done;

    logic        tick4 = 1'b0, load4 = 1'b0, ss4 = 1'b0;
    logic [7:0]  pmin4 = 8'h00, psec4 = 8'h00;
    logic [15:0] time4;
    logic        run4, exp4, done4;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    countdown_timer #(.PRESCALE(1)) dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load), .start_stop(start_stop),
        .preset_min(preset_min), .preset_sec(preset_sec),
        .time_reading(time_reading), .running(running), .expired(expired), .done(done)
    );

    countdown_timer #(.PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .tick(tick4), .load(load4), .start_stop(ss4),
        .preset_min(pmin4), .preset_sec(psec4),
        .time_reading(time4), .running(run4), .expired(exp4), .done(done4)
    );

    task automatic add(input logic ld, input logic ss, input logic tk,
                       input logic [7:0] pm, input logic [7:0] ps,
                       input logic [15:0] t, input logic run, input logic exp, input logic dn);
        vec_t v;
        v.ld = ld; v.ss = ss; v.tk = tk; v.pm = pm; v.ps = ps;
        v.t = t; v.run = run; v.exp = exp; v.dn = dn;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] t, input logic r,
                         input logic e, input logic d, input logic [15:0] et,
                         input logic er, input logic ee, input logic ed);
        n_vec++;
        if ({t, r, e, d} !== {et, er, ee, ed}) begin
            n_bad++;
            $display("FAIL %s: got time=%h run=%b exp=%b done=%b, want time=%h run=%b exp=%b done=%b",
                     name, t, r, e, d, et, er, ee, ed);
        end
    endtask

    task automatic step4(input logic ld, input logic ss, input logic tk,
                         input logic [7:0] pm, input logic [7:0] ps);
        load4 = ld; ss4 = ss; tick4 = tk; pmin4 = pm; psec4 = ps;
        @(posedge clk); #1;
        load4 = 1'b0; ss4 = 1'b0; tick4 = 1'b0;
    endtask

    initial begin
        // reset state and basic decrement with minute borrow
        add(0,0,0, 8'h00,8'h00, 16'h0000,0,0,0);
        add(1,0,0, 8'h01,8'h00, 16'h0100,0,0,0);
        add(0,1,0, 8'h00,8'h00, 16'h0100,1,0,0);
        add(0,0,1, 8'h00,8'h00, 16'h0059,1,0,0);
        // run to zero
        add(1,0,0, 8'h00,8'h02, 16'h0002,0,0,0);
        add(0,1,0, 8'h00,8'h00, 16'h0002,1,0,0);
        add(0,0,1, 8'h00,8'h00, 16'h0001,1,0,0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        add(0,0,1, 8'h00,8'h00, 16'h0002,1,0,1);
        add(0,0,0, 8'h00,8'h00, 16'h0002,1,0,0);
        add(0,0,1, 8'h00,8'h00, 16'h0001,1,0,0);
        add(0,1,0, 8'h00,8'h00, 16'h0001,0,0,0);
        add(0,1,1, 8'h00,8'h00, 16'h0001,1,0,0);
`else
        add(0,0,1, 8'h00,8'h00, 16'h0000,0,1,1);
        add(0,0,0, 8'h00,8'h00, 16'h0000,0,1,0);
        add(0,0,1, 8'h00,8'h00, 16'h0000,0,1,0);
        add(0,1,0, 8'h00,8'h00, 16'h0000,0,1,0);
        add(0,1,1, 8'h00,8'h00, 16'h0000,0,1,0);
`endif
        // clamping; load clears expired
        add(1,0,0, 8'hA3,8'h7C, 16'h9359,0,0,0);
        // pause / resume, ticks during pause ignored
        add(1,0,0, 8'h00,8'h10, 16'h0010,0,0,0);
        add(0,1,0, 8'h00,8'h00, 16'h0010,1,0,0);
        add(0,1,1, 8'h00,8'h00, 16'h0010,0,0,0);
        add(0,0,1, 8'h00,8'h00, 16'h0010,0,0,0);
        add(0,0,1, 8'h00,8'h00, 16'h0010,0,0,0);
        add(0,0,1, 8'h00,8'h00, 16'h0010,0,0,0);
        add(0,1,0, 8'h00,8'h00, 16'h0010,1,0,0);
        add(0,0,1, 8'h00,8'h00, 16'h0009,1,0,0);
        // load beats start_stop and tick; idle ignores tick
        add(1,1,1, 8'h00,8'h03, 16'h0003,0,0,0);
        add(0,0,1, 8'h00,8'h00, 16'h0003,0,0,0);
        // zero preset cannot start
        add(1,0,0, 8'h00,8'h00, 16'h0000,0,0,0);
        add(0,1,0, 8'h00,8'h00, 16'h0000,0,0,0);
        // full borrow chain and max count
        add(1,0,0, 8'h10,8'h00, 16'h1000,0,0,0);
        add(0,1,0, 8'h00,8'h00, 16'h1000,1,0,0);
        add(0,0,1, 8'h00,8'h00, 16'h0959,1,0,0);
        add(1,0,0, 8'h99,8'h59, 16'h9959,0,0,0);
        add(0,1,0, 8'h00,8'h00, 16'h9959,1,0,0);
        add(0,0,1, 8'h00,8'h00, 16'h9958,1,0,0);
        // single-second expiry
        add(1,0,0, 8'h00,8'h01, 16'h0001,0,0,0);
        add(0,1,0, 8'h00,8'h00, 16'h0001,1,0,0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        add(0,0,1, 8'h00,8'h00, 16'h0001,1,0,1);
`else
        add(0,0,1, 8'h00,8'h00, 16'h0000,0,1,1);
`endif

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            load = vecs[i].ld; start_stop = vecs[i].ss; tick = vecs[i].tk;
            preset_min = vecs[i].pm; preset_sec = vecs[i].ps;
            @(posedge clk); #1;
            load = 1'b0; start_stop = 1'b0; tick = 1'b0;
            check($sformatf("vec%0d", i), time_reading, running, expired, done,
                  vecs[i].t, vecs[i].run, vecs[i].exp, vecs[i].dn);
        end

        // reset mid-run overrides a simultaneous load
        load = 1'b1; preset_min = 8'h00; preset_sec = 8'h05;
        @(posedge clk); #1;
        load = 1'b0; start_stop = 1'b1;
        @(posedge clk); #1;
        start_stop = 1'b0; tick = 1'b1;
        @(posedge clk); #1;
        check("pre_reset", time_reading, running, expired, done, 16'h0004, 1'b1, 1'b0, 1'b0);
        reset = 1'b1; load = 1'b1; tick = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; load = 1'b0; tick = 1'b0;
        check("mid_reset", time_reading, running, expired, done, 16'h0000, 1'b0, 1'b0, 1'b0);

        // PRESCALE=4 instance
        step4(1, 0, 0, 8'h00, 8'h05);
        check("p4_load", time4, run4, exp4, done4, 16'h0005, 1'b0, 1'b0, 1'b0);
        step4(0, 1, 0, 8'h00, 8'h00);
        for (int k = 1; k <= 7; k++) begin
            step4(0, 0, 1, 8'h00, 8'h00);
            check($sformatf("p4_tick%0d", k), time4, run4, exp4, done4,
                  (k >= 4) ? 16'h0004 : 16'h0005, 1'b1, 1'b0, 1'b0);
        end
        step4(1, 0, 0, 8'h00, 8'h30);
        check("p4_reload", time4, run4, exp4, done4, 16'h0030, 1'b0, 1'b0, 1'b0);
        // prescaler must restart from zero: four more ticks for one second
        step4(0, 1, 0, 8'h00, 8'h00);
        for (int k = 1; k <= 4; k++) begin
            step4(0, 0, 1, 8'h00, 8'h00);
            check($sformatf("p4_after_load%0d", k), time4, run4, exp4, done4,
                  (k == 4) ? 16'h0029 : 16'h0030, 1'b1, 1'b0, 1'b0);
        end
        // tick with start_stop does not advance the prescaler
        step4(0, 0, 1, 8'h00, 8'h00);
        step4(0, 0, 1, 8'h00, 8'h00);
        step4(0, 0, 1, 8'h00, 8'h00);
        step4(0, 1, 1, 8'h00, 8'h00);
        step4(0, 1, 0, 8'h00, 8'h00);
        check("p4_ss_hold", time4, run4, exp4, done4, 16'h0029, 1'b1, 1'b0, 1'b0);
        step4(0, 0, 1, 8'h00, 8'h00);
        check("p4_ss_resume", time4, run4, exp4, done4, 16'h0028, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
